// File: rtl/led_scanner_pkg.sv
// Shared mode encoding and sizing helper for the LED scanner.
package led_scanner_pkg;

    localparam logic [1:0] MODE_BOUNCE  = 2'd0;
    localparam logic [1:0] MODE_WRAP_UP = 2'd1;
    localparam logic [1:0] MODE_WRAP_DN = 2'd2;
    localparam logic [1:0] MODE_HOLD    = 2'd3;

    // Index width for n positions, never narrower than one bit.
    function automatic int calc_pos_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Enable-style prescaler: counts CLOCK_50 cycles while run=1 and emits a one-cycle tick.
module led_tick_gen #(
    parameter int TICK_DIV = 5000000
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic run,
    output logic step,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV <= 2) ? 1 : $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_p0;

    // step is the edge on which the count wraps; tick is its registered copy.
    assign step = run && (cnt_p0 == CNT_LAST);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cnt_p0 <= '0;
            tick   <= 1'b0;
        end else begin
            tick <= step;
            if (step) begin
                cnt_p0 <= '0;
            end else if (run) begin
                cnt_p0 <= cnt_p0 + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/led_scanner.sv
// Scanning LED driver: bounce / wrap-up / wrap-down / hold stepping at a prescaled rate.
// Optional fading trail of previous positions when LED_SCANNER_TRAIL_EN is defined.
module led_scanner
    import led_scanner_pkg::*;
#(
    parameter int NUM_LEDS  = 10,
    parameter int TICK_DIV  = 5000000,
    parameter int TRAIL_LEN = 2,
    localparam int POS_W    = calc_pos_w(NUM_LEDS)
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                run,
    input  logic [1:0]          mode,
    output logic [NUM_LEDS-1:0] LEDR,
    output logic [POS_W-1:0]    pos,
    output logic                dir,
    output logic                tick
);

    localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_LEDS - 1);

    if (NUM_LEDS < 1 || NUM_LEDS > 64) begin : g_bad_num_leds
        $error("led_scanner: NUM_LEDS must be 1..64");
    end
    if (TICK_DIV < 1 || TICK_DIV > (1 << 26)) begin : g_bad_tick_div
        $error("led_scanner: TICK_DIV must be 1..2^26");
    end
    if (TRAIL_LEN < 0 || TRAIL_LEN > 7) begin : g_bad_trail_len
        $error("led_scanner: TRAIL_LEN must be 0..7");
    end

    logic             step;
    logic [POS_W-1:0] pos_p0, pos_nxt;
    logic             dir_p0, dir_nxt;

    led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .run      (run),
        .step     (step),
        .tick     (tick)
    );

    always_comb begin
        pos_nxt = pos_p0;
        dir_nxt = dir_p0;
        if (NUM_LEDS > 1) begin
            case (mode)
                MODE_BOUNCE: begin
                    if (dir_p0) begin
                        if (pos_p0 == POS_LAST) begin
                            pos_nxt = pos_p0 - POS_W'(1);
                            dir_nxt = 1'b0;
                        end else begin
                            pos_nxt = pos_p0 + POS_W'(1);
                        end
                    end else begin
                        if (pos_p0 == '0) begin
                            pos_nxt = POS_W'(1);
                            dir_nxt = 1'b1;
                        end else begin
                            pos_nxt = pos_p0 - POS_W'(1);
                        end
                    end
                end
                MODE_WRAP_UP: begin
                    pos_nxt = (pos_p0 == POS_LAST) ? '0 : pos_p0 + POS_W'(1);
                    dir_nxt = 1'b1;
                end
                MODE_WRAP_DN: begin
                    pos_nxt = (pos_p0 == '0) ? POS_LAST : pos_p0 - POS_W'(1);
                    dir_nxt = 1'b0;
                end
                default: begin
                    pos_nxt = pos_p0;
                    dir_nxt = dir_p0;
                end
            endcase
        end
    end

    // Position stage: advances on the same edge that raises tick.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            pos_p0 <= '0;
            dir_p0 <= 1'b1;
        end else if (step) begin
            pos_p0 <= pos_nxt;
            dir_p0 <= dir_nxt;
        end
    end

`ifdef LED_SCANNER_TRAIL_EN
    localparam int HIST_N = (TRAIL_LEN > 0) ? TRAIL_LEN : 1;

    logic [POS_W-1:0]  hist_pos_p0 [HIST_N];
    logic [HIST_N-1:0] hist_vld_p0;
    logic              hist_shift;

    // Hold mode and single-LED builds never move pos, so they never shift.
    assign hist_shift = step && (pos_nxt != pos_p0);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            hist_vld_p0 <= '0;
        end else if (hist_shift) begin
            for (int i = HIST_N - 1; i > 0; i--) begin
                hist_vld_p0[i] <= hist_vld_p0[i-1];
            end
            hist_vld_p0[0] <= (TRAIL_LEN > 0);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (hist_shift) begin
            for (int i = HIST_N - 1; i > 0; i--) begin
                hist_pos_p0[i] <= hist_pos_p0[i-1];
            end
            hist_pos_p0[0] <= pos_p0;
        end
    end
`endif

    always_comb begin
        LEDR = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            LEDR[i] = (pos_p0 == POS_W'(i));
`ifdef LED_SCANNER_TRAIL_EN
            for (int j = 0; j < TRAIL_LEN; j++) begin
                if (hist_vld_p0[j] && (hist_pos_p0[j] == POS_W'(i))) begin
                    LEDR[i] = 1'b1;
                end
            end
`endif
        end
    end

    assign pos = pos_p0;
    assign dir = dir_p0;

endmodule

// File: doc/led_scanner.md
LED_SCANNER -- requirements
Module: led_scanner

Interface
REQ-001 Parameter NUM_LEDS, default 10: number of LED outputs, legal range 1..64.
REQ-002 Parameter TICK_DIV, default 5000000: CLOCK_50 cycles per step, legal range 1..2^26.
REQ-003 Parameter TRAIL_LEN, default 2: number of trailing lit positions, legal range 0..7; used only with LED_SCANNER_TRAIL_EN.
REQ-004 Port CLOCK_50, input, 1 bit: the single clock; every flop is clocked on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port run, input, 1 bit: 1 advances the prescaler, 0 freezes the prescaler and the position.
REQ-007 Port mode, input, 2 bits: 0 selects bounce, 1 selects wrap-up, 2 selects wrap-down, 3 selects hold.
REQ-008 Port LEDR, output, NUM_LEDS bits: the LED drive pattern.
REQ-009 Port pos, output, POS_W bits: the current lit index, where POS_W = max(1, clog2(NUM_LEDS)).
REQ-010 Port dir, output, 1 bit: 1 means up (increasing index), 0 means down.
REQ-011 Port tick, output, 1 bit: a one-cycle pulse on each step event.

Function
REQ-012 The step rate comes from an enable-based prescaler on CLOCK_50; no divided or derived clock is generated.
REQ-013 Prescaler behaviour while run=1:
- it counts 0..TICK_DIV-1 and wraps;
- tick is registered and is high for exactly the one cycle after the count reaches TICK_DIV-1;
- with TICK_DIV=1, tick is high every cycle.
REQ-014 While run=0, the prescaler holds its value, tick=0, and pos and dir hold.
REQ-015 pos and dir update in the same cycle that tick is asserted, using the mode value sampled in the previous cycle.
REQ-016 Bounce (mode 0):
- dir=1 and pos<NUM_LEDS-1: pos+1;
- dir=1 and pos=NUM_LEDS-1: pos-1 and dir<=0;
- dir=0 and pos>0: pos-1;
- dir=0 and pos=0: pos+1 and dir<=1.
- The end positions are therefore shown for one step only.
REQ-017 Wrap-up (mode 1): pos+1, and NUM_LEDS-1 wraps to 0; dir<=1.
REQ-018 Wrap-down (mode 2): pos-1, and 0 wraps to NUM_LEDS-1; dir<=0.
REQ-019 Hold (mode 3): pos and dir are unchanged; tick still pulses.
REQ-020 Mode changes take effect at the next tick, without resetting pos. Bounce entered from a wrap mode uses the current dir.
REQ-021 With NUM_LEDS=1: pos stays 0, dir stays 1, and LEDR stays 1 in all modes.
REQ-022 With the trail feature absent, LEDR is one-hot: LEDR = 1 << pos.
REQ-023 LEDR is derived combinationally from registered state only, and never has an out-of-range bit set.

Reset
REQ-024 When reset=1 at a clock edge, the following take these values on that edge, regardless of run and mode:
- prescaler = 0;
- pos = 0;
- dir = 1;
- tick = 0;
- trail history = empty;
- LEDR = 1 (bit 0 only).
REQ-025 A reset asserted mid-step discards the pending step. The first tick after reset release occurs TICK_DIV cycles after release, with run=1.

Configuration
REQ-026 Macro LED_SCANNER_TRAIL_EN.
REQ-027 When LED_SCANNER_TRAIL_EN is defined:
- a shift register holds the last TRAIL_LEN previous pos values, each with a valid bit;
- LEDR is the OR of the one-hots of pos and every valid history entry;
- history shifts on each tick that changes pos;
- reset clears all valid bits;
- hold mode does not shift history.
REQ-028 When LED_SCANNER_TRAIL_EN is not defined, no history logic exists and REQ-022 applies. TRAIL_LEN is ignored.

Structure
REQ-029 Package led_scanner_pkg holds:
- the mode encoding constants MODE_BOUNCE, MODE_WRAP_UP, MODE_WRAP_DN, MODE_HOLD;
- a helper function computing POS_W.
REQ-030 Sub-module led_tick_gen (the prescaler with run and tick) is instantiated once; the position state machine and the LED decode stay in led_scanner.

Verification
REQ-031 NUM_LEDS=10, TICK_DIV=4, mode=0, run=1 after reset: tick every 4 cycles, and pos sequence 0,1,...,9,8,...,0,1 with dir flipping at 9 and at 0.
REQ-032 NUM_LEDS=10, mode=1 from pos=8: pos goes 9,0,1. Then switch to mode=2: pos goes 0,9,8, and dir=0.
REQ-033 Drop run=0 for 7 cycles mid-count: pos, dir and the prescaler are frozen and tick=0. Step cadence resumes exactly when run returns to 1.
REQ-034 Assert reset for 1 cycle at pos=5 with dir=0: the next cycle shows LEDR=10'b0000000001, pos=0 and dir=1. The first tick comes 4 cycles after reset release.
REQ-035 With LED_SCANNER_TRAIL_EN defined and TRAIL_LEN=2, bounce from reset: LEDR goes 001, then 011, then 111 (bits 0-2), then 1110.
REQ-036 NUM_LEDS=1 and TICK_DIV=1, all four modes: LEDR=1 and pos=0 every cycle, and tick=1 every cycle while run=1.
